// File: rtl/hazard_pkg.sv
// Shared constants and types for the MINI-RISC hazard controller.
// Opcode values mirror the legacy parameters.v definitions.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LSTALL = 2'd1,
        BFLUSH = 2'd2
    } hz_state_t;

    localparam logic [3:0] LBH  = 4'hA;
    localparam logic [3:0] LBL  = 4'hB;
    localparam logic [3:0] SETF = 4'hC;
    localparam logic [3:0] CPLF = 4'hD;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// slave: the controller itself; master: the control unit / datapath side.
interface hazard_ctrl_if #(
    parameter int RA_W    = 3,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*RA_W-1:0] src_D;
    logic [NUM_SRC-1:0]      src_valid_D;
    logic                    branch_D;
    logic [RA_W-1:0]         rd_E;
    logic [RA_W-1:0]         rd_W;
    logic                    reg_write_E;
    logic                    reg_write_W;
    logic                    mem_read_E;
    logic                    flag_write_E;
    logic                    branch_taken_E;
    logic                    cnt_clr;
    logic                    stall_F;
    logic                    stall_D;
    logic                    flush_F;
    logic                    flush_D;
    logic [2*NUM_SRC-1:0]    fwd_sel;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        flush_cnt;

    modport slave (
        input  src_D, src_valid_D, branch_D, rd_E, rd_W, reg_write_E, reg_write_W,
               mem_read_E, flag_write_E, branch_taken_E, cnt_clr,
        output stall_F, stall_D, flush_F, flush_D, fwd_sel, stall_cnt, flush_cnt
    );

    modport master (
        output src_D, src_valid_D, branch_D, rd_E, rd_W, reg_write_E, reg_write_W,
               mem_read_E, flag_write_E, branch_taken_E, cnt_clr,
        input  stall_F, stall_D, flush_F, flush_D, fwd_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_fwd_match.sv
// Single-operand forwarding comparator: picks E, W or the register file.
// A load in E has no data yet, so it never forwards from E.
module hazard_fwd_match
    import hazard_pkg::*;
#(
    parameter int RA_W = 3
) (
    input  logic [RA_W-1:0] src,
    input  logic            src_valid,
    input  logic [RA_W-1:0] rd_E,
    input  logic            reg_write_E,
    input  logic            mem_read_E,
    input  logic [RA_W-1:0] rd_W,
    input  logic            reg_write_W,
    output logic [1:0]      sel
);

    always_comb begin
        sel = FWD_RF;
        if (src_valid && reg_write_E && !mem_read_E && (rd_E == src)) begin
            sel = FWD_E;
        end else if (src_valid && reg_write_W && (rd_W == src)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use / flag-use stalls,
// branch flush windows and saturating stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W           = 3,
    parameter int NUM_SRC        = 2,
    parameter int LOAD_LAT       = 1,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 16
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);

    localparam logic [2:0] LOAD_WIN = 3'(LOAD_LAT - 1);
    localparam logic [2:0] BR_WIN   = 3'(BRANCH_PENALTY - 1);

    hz_state_t  state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       load_use, flag_haz;
    logic       stall, flush_F, flush_D;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        hazard_fwd_match #(.RA_W(RA_W)) u_match (
            .src         (hz.src_D[i*RA_W +: RA_W]),
            .src_valid   (hz.src_valid_D[i]),
            .rd_E        (hz.rd_E),
            .reg_write_E (hz.reg_write_E),
            .mem_read_E  (hz.mem_read_E),
            .rd_W        (hz.rd_W),
            .reg_write_W (hz.reg_write_W),
            .sel         (hz.fwd_sel[2*i +: 2])
        );
    end

    always_comb begin
        load_use = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (hz.src_valid_D[i] && (hz.src_D[i*RA_W +: RA_W] == hz.rd_E)) begin
                load_use = hz.mem_read_E && hz.reg_write_E;
            end
        end
        flag_haz = hz.branch_D && hz.flag_write_E;
    end

    // Window counter holds the cycles still to run after the current one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        flush_F   = 1'b0;
        flush_D   = 1'b0;
        if (hz.branch_taken_E) begin
            flush_F = 1'b1;
            flush_D = 1'b1;
            if (BR_WIN != 3'd0) begin
                state_nxt = BFLUSH;
                cnt_nxt   = BR_WIN;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_use) begin
                        stall   = 1'b1;
                        flush_D = 1'b1;
                        if (LOAD_WIN != 3'd0) begin
                            state_nxt = LSTALL;
                            cnt_nxt   = LOAD_WIN;
                        end
                    end else if (flag_haz) begin
                        stall   = 1'b1;
                        flush_D = 1'b1;
                    end
                end
                LSTALL, BFLUSH: begin
                    stall   = (state == LSTALL);
                    flush_F = (state == BFLUSH);
                    flush_D = 1'b1;
                    cnt_nxt = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            hz.stall_cnt <= '0;
            hz.flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (hz.cnt_clr) begin
                hz.stall_cnt <= '0;
                hz.flush_cnt <= '0;
            end else begin
                if (stall && (hz.stall_cnt != '1)) hz.stall_cnt <= hz.stall_cnt + 1'b1;
                if (flush_F && (hz.flush_cnt != '1)) hz.flush_cnt <= hz.flush_cnt + 1'b1;
            end
        end
    end

    assign hz.stall_F = stall;
    assign hz.stall_D = stall;
    assign hz.flush_F = flush_F;
    assign hz.flush_D = flush_D;

endmodule
